bcd_conv_scheduler: RTL
=======================

// Module: bcd_conv_scheduler
// PURPOSE
//  Time-multiplexes one serial double-dabble engine across the six clock/calendar fields
//  (ss, mm, hh, dd, mo, yyyy). It replaces six parallel combinational converters with one
//  shift/add-3 datapath driven by an FSM.
//  Sits between the time/date counters and the 7-seg display driver.
//  Publishes all six BCD results together, so the display never shows a torn update.
// PARAMETERS
//  YEAR_W   12   year_bin width; must be <=13 so the value fits 4 BCD digits (<=9999)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       request conversion; sampled only in IDLE
//  sec_bin    in   6       seconds, binary
//  min_bin    in   6       minutes, binary
//  hour_bin   in   5       hours, binary
//  day_bin    in   5       day of month, binary
//  month_bin  in   4       month, binary
//  year_bin   in   YEAR_W  year, binary
//  bcd_ss/bcd_mm/bcd_hh/bcd_dd/bcd_mo  out 8 each   2-digit packed BCD {tens,units}
//  bcd_yyyy   out  16      4-digit packed BCD {thousands,hundreds,tens,units}
//  busy       out  1       high from the accepting edge until the final STORE edge
//  done       out  1       one-cycle pulse; outputs updated on the same edge
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0; all bcd_* outputs, shadows and snapshot = 0.
//   Reset mid-conversion aborts with no partial publish.
//  FSM states: IDLE -> LOAD -> SHIFT -> STORE -> (LOAD | IDLE).
//  - IDLE: on start=1, snapshot all six inputs, set field idx=0, go to LOAD, busy=1.
//    Later input changes do not affect the running conversion.
//  - LOAD: sreg <= {zero digit nibbles, snapshot[idx]}; cnt <= W(idx).
//    W = 6,6,5,5,4,YEAR_W for idx 0..5. Go to SHIFT.
//  - SHIFT: each cycle, every BCD nibble >=5 gets +3 first, then the whole sreg shifts
//    left by 1; cnt--. When cnt reaches 0 (after exactly W shifts), go to STORE.
//  - STORE: write the digit nibbles to shadow[idx].
//    idx<5: idx++ and go to LOAD.
//    idx==5: copy all shadows to the bcd_* outputs, pulse done=1, clear busy, go to IDLE.
//  Latency: each field takes W+2 edges. Accept at edge k gives done/outputs valid after
//   edge k+50 (YEAR_W=12).
//  Restart: earliest is edge k+51 (start is ignored in the STORE cycle).
//   start held high gives one conversion every 51 cycles.
//  start while busy is ignored; requests are not queued.
//  Widths: sreg is 16 digit bits + YEAR_W bits. 2-digit fields use only the low 2 nibbles.
//  Range: any input value is converted exactly (e.g. 63, 31, 15, 4095).
//   No range clamping; upstream owns legality.
//  Outputs hold their last published value between conversions.
// CONFIGURATION
//  BCD_AUTO_REFRESH_EN defined:
//   - In IDLE, if any live input differs from the last snapshot, a conversion starts
//     exactly as if start=1.
//   - start is still honoured.
//   - The reset snapshot is 0, so the first nonzero input self-triggers.
//  BCD_AUTO_REFRESH_EN undefined:
//   - Conversions start only on start.
//   - No compare logic is synthesised.
// TESTING
//  1 start, inputs 59/7/23/31/12/2024 -> after 50 cycles done=1;
//    bcd_ss=8'h59, bcd_mm=8'h07, bcd_hh=8'h23, bcd_dd=8'h31, bcd_mo=8'h12,
//    bcd_yyyy=16'h2024.
//  2 maxima 63/63/31/31/15/4095 -> 8'h63, 8'h63, 8'h31, 8'h31, 8'h15, 16'h4095.
//    All-zero inputs -> all 0, done still pulses.
//  3 change every input 10 cycles after start -> outputs match the start-time snapshot;
//    a second start converts the new values.
//  4 start pulses at cycles 5 and 30 of a conversion -> ignored, exactly one done.
//    start held high -> done every 51 cycles.
//  5 rst at cycle 20 of a conversion -> busy=0, done=0, outputs 0 next cycle.
//    A fresh start completes normally.
//  6 BCD_AUTO_REFRESH_EN: min_bin 7->8 in IDLE with start=0 -> busy next cycle, bcd_mm=8'h08
//    50 cycles later. Without the macro -> no activity.

Source files
------------

// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler
// Shares one serial double-dabble (shift / add-3) engine across the six
// clock/calendar fields (ss, mm, hh, dd, mo, yyyy).
// All six BCD results are published on the same edge, so the display never
// shows a torn update.
// Optional feature: define BCD_AUTO_REFRESH_EN to start a conversion from IDLE
// whenever a live input differs from the last snapshot.
// YEAR_W must be 6..13 so that the year fits in four BCD digits and every
// 2-digit field still fits in the binary part of the shift register.
module bcd_conv_scheduler #(
  parameter int YEAR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        sec_bin,
  input  logic [5:0]        min_bin,
  input  logic [4:0]        hour_bin,
  input  logic [4:0]        day_bin,
  input  logic [3:0]        month_bin,
  input  logic [YEAR_W-1:0] year_bin,
  output logic [7:0]        bcd_ss,
  output logic [7:0]        bcd_mm,
  output logic [7:0]        bcd_hh,
  output logic [7:0]        bcd_dd,
  output logic [7:0]        bcd_mo,
  output logic [15:0]       bcd_yyyy,
  output logic              busy,
  output logic              done
);

  // Shift register: 4 BCD digit nibbles on top, binary operand below.
  localparam int SW = 16 + YEAR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE
  } state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [4:0]        cnt;
  logic [SW-1:0]     sreg;

  logic [5:0]        snap_ss;
  logic [5:0]        snap_mm;
  logic [4:0]        snap_hh;
  logic [4:0]        snap_dd;
  logic [3:0]        snap_mo;
  logic [YEAR_W-1:0] snap_yyyy;

  logic [7:0]        shadow_ss;
  logic [7:0]        shadow_mm;
  logic [7:0]        shadow_hh;
  logic [7:0]        shadow_dd;
  logic [7:0]        shadow_mo;
  logic [15:0]       shadow_yyyy;

  logic [YEAR_W-1:0] load_val;
  logic [4:0]        load_w;
  logic [SW-1:0]     adj;
  logic [15:0]       digits;
  logic              input_changed;
  logic              trigger;

`ifdef BCD_AUTO_REFRESH_EN
  // Any live input that differs from the last snapshot requests a refresh.
  assign input_changed = (sec_bin   != snap_ss) || (min_bin  != snap_mm) ||
                         (hour_bin  != snap_hh) || (day_bin  != snap_dd) ||
                         (month_bin != snap_mo) || (year_bin != snap_yyyy);
`else
  assign input_changed = 1'b0;
`endif

  assign trigger = start | input_changed;
  assign digits  = sreg[SW-1 -: 16];

  // Select the snapshot operand for the current field, left-aligned in the
  // binary part so that exactly W shifts move all of its bits into the digits.
  always_comb begin
    load_val = '0;
    load_w   = 5'(YEAR_W);
    case (idx)
      3'd0: begin
        load_val = YEAR_W'(snap_ss) << (YEAR_W - 6);
        load_w   = 5'd6;
      end
      3'd1: begin
        load_val = YEAR_W'(snap_mm) << (YEAR_W - 6);
        load_w   = 5'd6;
      end
      3'd2: begin
        load_val = YEAR_W'(snap_hh) << (YEAR_W - 5);
        load_w   = 5'd5;
      end
      3'd3: begin
        load_val = YEAR_W'(snap_dd) << (YEAR_W - 5);
        load_w   = 5'd5;
      end
      3'd4: begin
        load_val = YEAR_W'(snap_mo) << (YEAR_W - 4);
        load_w   = 5'd4;
      end
      default: begin
        load_val = snap_yyyy;
        load_w   = 5'(YEAR_W);
      end
    endcase
  end

  // Add-3 correction: every digit nibble >= 5 is bumped before the shift.
  always_comb begin
    adj = sreg;
    for (int d = 0; d < 4; d++) begin
      if (sreg[YEAR_W + 4*d +: 4] >= 4'd5) begin
        adj[YEAR_W + 4*d +: 4] = sreg[YEAR_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  // Scheduler FSM: snapshot, then LOAD/SHIFT/STORE each field, publish at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      cnt         <= 5'd0;
      sreg        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      snap_ss     <= '0;
      snap_mm     <= '0;
      snap_hh     <= '0;
      snap_dd     <= '0;
      snap_mo     <= '0;
      snap_yyyy   <= '0;
      shadow_ss   <= '0;
      shadow_mm   <= '0;
      shadow_hh   <= '0;
      shadow_dd   <= '0;
      shadow_mo   <= '0;
      shadow_yyyy <= '0;
      bcd_ss      <= '0;
      bcd_mm      <= '0;
      bcd_hh      <= '0;
      bcd_dd      <= '0;
      bcd_mo      <= '0;
      bcd_yyyy    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            snap_ss   <= sec_bin;
            snap_mm   <= min_bin;
            snap_hh   <= hour_bin;
            snap_dd   <= day_bin;
            snap_mo   <= month_bin;
            snap_yyyy <= year_bin;
            idx       <= 3'd0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          sreg  <= {16'h0000, load_val};
          cnt   <= load_w;
          state <= SHIFT;
        end
        SHIFT: begin
          sreg <= adj << 1;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= STORE;
          end
        end
        STORE: begin
          case (idx)
            3'd0:    shadow_ss   <= digits[7:0];
            3'd1:    shadow_mm   <= digits[7:0];
            3'd2:    shadow_hh   <= digits[7:0];
            3'd3:    shadow_dd   <= digits[7:0];
            3'd4:    shadow_mo   <= digits[7:0];
            default: shadow_yyyy <= digits;
          endcase
          if (idx == 3'd5) begin
            bcd_ss   <= shadow_ss;
            bcd_mm   <= shadow_mm;
            bcd_hh   <= shadow_hh;
            bcd_dd   <= shadow_dd;
            bcd_mo   <= shadow_mo;
            bcd_yyyy <= digits;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            idx   <= idx + 3'd1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
